// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: FSM encoding and widths.
package hazard_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    LWAIT = 1'b1
  } state_t;

  // Register 0 is hard-wired to zero and never creates a dependency.
  localparam int unsigned REG_ZERO = 0;

  // Wait counter width; covers LOAD_LAT up to 15.
  localparam int WCNT_W = 4;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter used for stall accounting.
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      cnt_o <= '0;
    else if (en_i && (cnt_o != '1))
      cnt_o <= cnt_o + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control beside ID: load-use, mul/div interlock, branch squash.
// Define HAZARD_PERF_EN to build the stall performance counter.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int R_AW     = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [R_AW-1:0]  ID_rs_i,
  input  logic [R_AW-1:0]  ID_rt_i,
  input  logic             ID_rs_used_i,
  input  logic             ID_rt_used_i,
  input  logic             ID_mdu_use_i,
  input  logic [R_AW-1:0]  EX_rt_i,
  input  logic             EX_mem_read_i,
  input  logic             mdu_busy_i,
  input  logic             EX_branch_taken_i,
  output logic             pc_keep_o,
  output logic             IF_ID_keep_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_zero_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [WCNT_W-1:0] LAT_M1 = WCNT_W'(LOAD_LAT - 1);
  localparam bit                MULTI  = (LOAD_LAT > 1);

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              load_hz, mdu_hz;

  assign load_hz = EX_mem_read_i && (EX_rt_i != R_AW'(REG_ZERO)) &&
                   ((ID_rs_used_i && (ID_rs_i == EX_rt_i)) ||
                    (ID_rt_used_i && (ID_rt_i == EX_rt_i)));
  assign mdu_hz  = ID_mdu_use_i && mdu_busy_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wcnt_nxt      = wcnt;
    pc_keep_o     = 1'b0;
    IF_ID_keep_o  = 1'b0;
    IF_ID_flush_o = 1'b0;
    ID_EX_zero_o  = 1'b0;
    if (EX_branch_taken_i) begin
      // Let the PC take the target; whatever sits in ID is wrong-path.
      IF_ID_flush_o = 1'b1;
      ID_EX_zero_o  = 1'b1;
      state_nxt     = IDLE;
      wcnt_nxt      = '0;
    end else if (state == LWAIT) begin
      pc_keep_o    = 1'b1;
      IF_ID_keep_o = 1'b1;
      ID_EX_zero_o = 1'b1;
      if (wcnt == WCNT_W'(1)) begin
        state_nxt = IDLE;
        wcnt_nxt  = '0;
      end else begin
        wcnt_nxt  = wcnt - 1'b1;
      end
    end else if (load_hz) begin
      pc_keep_o    = 1'b1;
      IF_ID_keep_o = 1'b1;
      ID_EX_zero_o = 1'b1;
      if (MULTI) begin
        state_nxt = LWAIT;
        wcnt_nxt  = LAT_M1;
      end
    end else if (mdu_hz) begin
      pc_keep_o    = 1'b1;
      IF_ID_keep_o = 1'b1;
      ID_EX_zero_o = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_counter #(.CNT_W(CNT_W)) u_perf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (pc_keep_o),
    .cnt_o   (stall_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomized + directed bench for hazard_ctrl_unit at LOAD_LAT 1 and 3.
module tb_hazard_ctrl_unit;
  localparam int R_AW  = 5;
  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [R_AW-1:0] id_rs, id_rt, ex_rt;
  logic id_rs_used, id_rt_used, id_mdu, ex_mr, busy, br;

  logic pc1, ifk1, fl1, zr1, pc3, ifk3, fl3, zr3;
  logic [CNT_W-1:0] cnt1, cnt3;

  hazard_ctrl_unit #(.R_AW(R_AW), .LOAD_LAT(1), .CNT_W(CNT_W)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .ID_rs_i(id_rs), .ID_rt_i(id_rt),
    .ID_rs_used_i(id_rs_used), .ID_rt_used_i(id_rt_used), .ID_mdu_use_i(id_mdu),
    .EX_rt_i(ex_rt), .EX_mem_read_i(ex_mr), .mdu_busy_i(busy),
    .EX_branch_taken_i(br), .pc_keep_o(pc1), .IF_ID_keep_o(ifk1),
    .IF_ID_flush_o(fl1), .ID_EX_zero_o(zr1), .stall_cnt_o(cnt1));

  hazard_ctrl_unit #(.R_AW(R_AW), .LOAD_LAT(3), .CNT_W(CNT_W)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .ID_rs_i(id_rs), .ID_rt_i(id_rt),
    .ID_rs_used_i(id_rs_used), .ID_rt_used_i(id_rt_used), .ID_mdu_use_i(id_mdu),
    .EX_rt_i(ex_rt), .EX_mem_read_i(ex_mr), .mdu_busy_i(busy),
    .EX_branch_taken_i(br), .pc_keep_o(pc3), .IF_ID_keep_o(ifk3),
    .IF_ID_flush_o(fl3), .ID_EX_zero_o(zr3), .stall_cnt_o(cnt3));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: number of further stall cycles still owed, plus stall total.
  int rem1, rem3;
  logic [CNT_W-1:0] mcnt1, mcnt3;

  function automatic bit m_load_hz();
    return ex_mr && (ex_rt != 0) &&
           ((id_rs_used && id_rs == ex_rt) || (id_rt_used && id_rt == ex_rt));
  endfunction

  // {pc_keep, IF_ID_keep, IF_ID_flush, ID_EX_zero}
  function automatic logic [3:0] exp_ctl(input int rem);
    if (br) return 4'b0011;
    if (rem > 0) return 4'b1101;
    if (m_load_hz() || (id_mdu && busy)) return 4'b1101;
    return 4'b0000;
  endfunction

  function automatic int nxt_rem(input int rem, input int lat);
    if (br) return 0;
    if (rem > 0) return rem - 1;
    if (m_load_hz()) return lat - 1;
    return 0;
  endfunction

  function automatic logic [CNT_W-1:0] nxt_cnt(input logic [CNT_W-1:0] c, input int rem);
    logic [3:0] e;
    e = exp_ctl(rem);
    if (e[3] && c != '1) return c + 1'b1;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem1 <= 0; rem3 <= 0; mcnt1 <= '0; mcnt3 <= '0;
    end else begin
      rem1  <= nxt_rem(rem1, 1);
      rem3  <= nxt_rem(rem3, 3);
      mcnt1 <= nxt_cnt(mcnt1, rem1);
      mcnt3 <= nxt_cnt(mcnt3, rem3);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_ctl1", {pc1, ifk1, fl1, zr1}, exp_ctl(rem1));
      chk("model_ctl3", {pc3, ifk3, fl3, zr3}, exp_ctl(rem3));
      chk("model_cnt1", cnt1, PERF ? mcnt1 : '0);
      chk("model_cnt3", cnt3, PERF ? mcnt3 : '0);
    end
  end

  task automatic drv(input bit mr, input int ert, input int rs, input bit rsu,
                     input int rt, input bit rtu, input bit mdu, input bit bsy, input bit b);
    ex_mr = mr; ex_rt = R_AW'(ert); id_rs = R_AW'(rs); id_rs_used = rsu;
    id_rt = R_AW'(rt); id_rt_used = rtu; id_mdu = mdu; busy = bsy; br = b;
  endtask

  task automatic quiet();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    quiet();
    #12;
    chk("rst_ctl3", {pc3, ifk3, fl3, zr3}, 4'b0000);
    chk("rst_cnt3", cnt3, '0);
    rst_n = 1'b1;

    // load-use: lw r5 in EX, ID reads r5
    cyc(); drv(1, 5, 5, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu1_c1", {pc1, ifk1, fl1, zr1}, 4'b1101);
    chk("lu3_c1", {pc3, ifk3, fl3, zr3}, 4'b1101);
    cyc(); drv(1, 9, 5, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu1_c2", pc1, 1'b0);
    chk("lu3_c2", {pc3, ifk3, fl3, zr3}, 4'b1101);
    cyc();
    @(negedge clk);
    chk("lu3_c3", pc3, 1'b1);
    cyc(); quiet();
    @(negedge clk);
    chk("lu3_c4", {pc3, ifk3, fl3, zr3}, 4'b0000);
    chk("lu1_cnt", cnt1, PERF ? 32'd1 : 32'd0);
    chk("lu3_cnt", cnt3, PERF ? 32'd3 : 32'd0);

    // r0 and unused rt never hazard
    cyc(); drv(1, 0, 0, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("r0_3", pc3, 1'b0);
    cyc(); drv(1, 7, 3, 1, 7, 0, 0, 0, 0);
    @(negedge clk);
    chk("rtunused_3", pc3, 1'b0);
    chk("rtunused_1", pc1, 1'b0);

    // taken branch in second stall cycle
    cyc(); drv(1, 5, 5, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("br_c1", pc3, 1'b1);
    cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("br_c2", {pc3, ifk3, fl3, zr3}, 4'b0011);
    cyc(); quiet();
    @(negedge clk);
    chk("br_c3", {pc3, ifk3, fl3, zr3}, 4'b0000);

    // mul/div busy for 4 cycles
    for (int i = 0; i < 4; i++) begin
      cyc(); drv(0, 0, 0, 0, 0, 0, 1, 1, 0);
      @(negedge clk);
      chk("mdu_busy", {pc3, ifk3, fl3, zr3}, 4'b1101);
    end
    cyc(); drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("mdu_done", {pc3, ifk3, fl3, zr3}, 4'b0000);

    // async reset mid-LWAIT
    cyc(); drv(1, 5, 5, 1, 0, 0, 0, 0, 0);
    cyc(); quiet();
    @(negedge clk);
    chk("rstw_pre", pc3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_ctl", {pc3, ifk3, fl3, zr3}, 4'b0000);
    chk("rstw_cnt", cnt3, '0);
    @(negedge clk); #2 rst_n = 1'b1;
    cyc(); drv(1, 5, 0, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    chk("post_c1", pc3, 1'b1);
    cyc(); quiet();
    @(negedge clk);
    chk("post_c2", pc3, 1'b1);
    cyc();
    @(negedge clk);
    chk("post_c3", pc3, 1'b1);
    cyc();
    @(negedge clk);
    chk("post_c4", pc3, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      drv(($urandom % 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom % 2,
          $urandom_range(0, 3), $urandom % 2, ($urandom % 4) == 0, $urandom % 2,
          ($urandom % 8) == 0);
    end
    cyc(); quiet();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the single-bubble load-use detector in the 5-stage MIPS pipeline; sits beside the ID stage.
Generates PC/IF-ID hold, IF-ID flush and ID-EX bubble controls for three cases:
- load-use hazards with configurable memory latency (multi-cycle stall FSM);
- interlock against a busy multi-cycle mul/div unit;
- taken-branch squash.
Optional stall performance counter.

Parameters:
R_AW, 5, register-address width (32 GPRs).
LOAD_LAT, 1, stall cycles inserted per load-use hazard; legal 1..15.
CNT_W, 32, width of the stall performance counter.

Ports:
clk_i  in  1  pipeline clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
ID_rs_i  in  R_AW  rs address of instruction in ID
ID_rt_i  in  R_AW  rt address of instruction in ID
ID_rs_used_i  in  1  ID instruction reads rs
ID_rt_used_i  in  1  ID instruction reads rt
ID_mdu_use_i  in  1  ID instruction is mult/div/mfhi/mflo
EX_rt_i  in  R_AW  destination of instruction in EX
EX_mem_read_i  in  1  EX instruction is a load
mdu_busy_i  in  1  mul/div unit still computing
EX_branch_taken_i  in  1  branch/jump resolved taken in EX
pc_keep_o  out  1  hold PC
IF_ID_keep_o  out  1  hold IF/ID register
IF_ID_flush_o  out  1  clear IF/ID register to NOP
ID_EX_zero_o  out  1  load bubble into ID/EX
stall_cnt_o  out  CNT_W  total stalled cycles (see optional feature)

Behaviour:
- Reset (async, rst_n_i low): state IDLE, wait counter 0, stall_cnt_o 0. All control outputs 0 whenever state is IDLE and inputs are quiet.
- load_hz (combinational): EX_mem_read_i AND EX_rt_i != 0 AND ((ID_rs_used_i AND ID_rs_i == EX_rt_i) OR (ID_rt_used_i AND ID_rt_i == EX_rt_i)). Register 0 never hazards.
- mdu_hz (combinational): ID_mdu_use_i AND mdu_busy_i.
- FSM states: IDLE, LWAIT.
- IDLE + load_hz, no branch:
  - stall this cycle: pc_keep_o = IF_ID_keep_o = ID_EX_zero_o = 1.
  - If LOAD_LAT > 1, go to LWAIT with wcnt = LOAD_LAT-1; otherwise stay IDLE.
- LWAIT:
  - stall outputs asserted unconditionally; EX inputs ignored, since EX holds a bubble.
  - wcnt decrements each cycle; wcnt == 1 returns to IDLE next edge.
  - Total stall per hazard is exactly LOAD_LAT cycles.
- mdu_hz in IDLE: stall outputs asserted combinationally every cycle busy persists. No state change. Zero added latency when busy drops.
- Priority: EX_branch_taken_i > LWAIT stall > load_hz/mdu_hz.
- Taken branch, in any state:
  - IF_ID_flush_o = ID_EX_zero_o = 1; pc_keep_o = IF_ID_keep_o = 0, so the PC loads the target.
  - FSM forced to IDLE next edge and wcnt cleared; the stalled ID instruction is wrong-path.
- Load_hz and mdu_hz together: single stall; FSM follows the load path.
- Outputs are combinational from state plus inputs. No registered output latency.

Optional Feature:
HAZARD_PERF_EN:
- Defined: stall_cnt_o increments by 1 on every clock edge where pc_keep_o is 1. It saturates at all-ones (no wrap) and resets to 0 asynchronously.
- Undefined: no counter flops; stall_cnt_o is tied to 0.

Decomposition:
- Shared package hazard_pkg:
  - FSM state encoding (IDLE = 1'b0, LWAIT = 1'b1);
  - REG_ZERO constant;
  - wcnt width constant (4 bits, covering LOAD_LAT up to 15).
- One sub-module, hazard_perf_counter (CNT_W saturating counter with enable), instantiated only under HAZARD_PERF_EN.

Test Plan:
1. LOAD_LAT=1: EX lw rt=5, ID add rs=5 (rs_used) -> keep/zero high exactly 1 cycle, FSM stays IDLE; stall_cnt_o 0->1.
2. LOAD_LAT=3: same hazard -> keep/zero high 3 consecutive cycles, then 0; EX_rt_i changed to 9 during cycles 2-3 has no effect; stall_cnt_o = 3.
3. EX lw rt=0, ID rs=0; also EX lw rt=7 with ID rt=7 but rt_used=0 -> no stall in either case.
4. LOAD_LAT=3: EX_branch_taken_i=1 in the 2nd stall cycle -> that cycle flush=1, zero=1, keep=0; next cycle all outputs 0, state IDLE.
5. ID_mdu_use_i=1, mdu_busy_i high 4 cycles -> keep/zero high 4 cycles, deassert in the cycle busy drops.
6. rst_n_i low mid-LWAIT (async, off-edge) -> outputs 0 immediately, stall_cnt_o 0; after release a new hazard stalls the full LOAD_LAT.
